// File: rtl/shift_add_pkg.sv
// Shared types for the sequential shift-and-add multiplier.
//   state_e   : controller states (2-bit encoding)
//   step_op_e : operation applied to the accumulator on one iteration step
package shift_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2
  } step_op_e;

endpackage

// File: rtl/shift_add_step.sv
// One combinational iteration of the shift-and-add multiplier.
// Applies op_i (none / add / subtract multiplicand) to the WIDTH+1-bit
// accumulator, then shifts {sum, multiplier} right by one bit.
// Configuration macro: SHIFT_ADD_SIGNED_EN selects an arithmetic shift
// (sum MSB replicated); otherwise the shift is logical and the adder carry
// lands in the accumulator MSB.
// Ports:
//   acc_i     in  WIDTH+1  current accumulator
//   mplr_hi_i in  WIDTH-1  multiplier bits [WIDTH-1:1] (bit 0 only steers op_i)
//   mcand_i   in  WIDTH+1  extended multiplicand
//   op_i      in  2        step operation chosen by the controller
//   acc_o     out WIDTH+1  next accumulator
//   mplr_o    out WIDTH    next multiplier / low product bits
module shift_add_step
  import shift_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   acc_i,
  input  logic [WIDTH-2:0] mplr_hi_i,
  input  logic [WIDTH:0]   mcand_i,
  input  step_op_e         op_i,
  output logic [WIDTH:0]   acc_o,
  output logic [WIDTH-1:0] mplr_o
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = acc_i;
    case (op_i)
      OP_ADD:  sum = acc_i + mcand_i;
      OP_SUB:  sum = acc_i - mcand_i;
      default: sum = acc_i;
    endcase
  end

`ifdef SHIFT_ADD_SIGNED_EN
  assign acc_o = {sum[WIDTH], sum[WIDTH:1]};
`else
  assign acc_o = {1'b0, sum[WIDTH:1]};
`endif

  // The bit shifted out of the sum becomes the next product bit.
  assign mplr_o = {sum[0], mplr_hi_i};

endmodule

// File: rtl/shift_add_mult_seq.sv
// Sequential shift-and-add multiplier: captures A and B on an accepted load,
// iterates one multiplier bit per clock for WIDTH clocks, then presents the
// 2*WIDTH-bit product on p with a one-cycle done strobe. p holds until the
// next completion or reset.
// Configuration macro: SHIFT_ADD_SIGNED_EN -> two's complement operands and
// product (multiplicand sign-extended, final step subtracts). Undefined ->
// unsigned operation.
// Ports:
//   clk  in  1        rising-edge clock
//   rst  in  1        synchronous active-high reset (aborts any operation)
//   load in  1        start request, honoured only while busy=0
//   A    in  WIDTH    multiplicand
//   B    in  WIDTH    multiplier
//   p    out 2*WIDTH  product
//   busy out 1        high while iterating
//   done out 1        one-cycle strobe when p is updated
module shift_add_mult_seq
  import shift_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] p,
  output logic               busy,
  output logic               done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH:0]       acc_q, acc_d;
  logic [WIDTH:0]       mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplr_q, mplr_d;

  logic [WIDTH:0]       mcand_ext;
  step_op_e             step_op;
  logic [WIDTH:0]       acc_nxt;
  logic [WIDTH-1:0]     mplr_nxt;

`ifdef SHIFT_ADD_SIGNED_EN
  assign mcand_ext = {A[WIDTH-1], A};
`else
  assign mcand_ext = {1'b0, A};
`endif

  // The multiplier LSB picks the operation; in signed mode the MSB of B
  // carries negative weight, so the last step subtracts.
  always_comb begin
    step_op = OP_NONE;
    if (mplr_q[0]) begin
`ifdef SHIFT_ADD_SIGNED_EN
      step_op = (cnt_q == LAST_CNT) ? OP_SUB : OP_ADD;
`else
      step_op = OP_ADD;
`endif
    end
  end

  shift_add_step #(.WIDTH(WIDTH)) u_step (
    .acc_i     (acc_q),
    .mplr_hi_i (mplr_q[WIDTH-1:1]),
    .mcand_i   (mcand_q),
    .op_i      (step_op),
    .acc_o     (acc_nxt),
    .mplr_o    (mplr_nxt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (load) begin
          state_d = RUN;
          mcand_d = mcand_ext;
          mplr_d  = B;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        acc_d  = acc_nxt;
        mplr_d = mplr_nxt;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // The product fits in 2*WIDTH bits, so the accumulator MSB is redundant.
          p_d     = {acc_nxt[WIDTH-1:0], mplr_nxt};
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control and visible outputs: reset clears them, aborting any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Datapath registers are always reloaded on accept, so they carry no reset.
  always_ff @(posedge clk) begin
    acc_q   <= acc_d;
    mcand_q <= mcand_d;
    mplr_q  <= mplr_d;
  end

  assign p    = p_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_shift_add_mult_seq.sv
module tb_shift_add_mult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        load8, load16;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic [15:0] p8;
  logic [31:0] p16;
  logic        busy8, done8, busy16, done16;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] last_p8  = '0;
  logic [31:0] last_p16 = '0;

  always #5 clk = ~clk;

  shift_add_mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .load(load8), .A(a8), .B(b8),
    .p(p8), .busy(busy8), .done(done8)
  );

  shift_add_mult_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .load(load16), .A(a16), .B(b16),
    .p(p16), .busy(busy16), .done(done16)
  );

  // Reference products from plain integer multiplication.
  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b);
    longint x, y;
`ifdef SHIFT_ADD_SIGNED_EN
    x = longint'($signed(a));
    y = longint'($signed(b));
`else
    x = longint'(a);
    y = longint'(b);
`endif
    return 16'(x * y);
  endfunction

  function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b);
    longint x, y;
`ifdef SHIFT_ADD_SIGNED_EN
    x = longint'($signed(a));
    y = longint'($signed(b));
`else
    x = longint'(a);
    y = longint'(b);
`endif
    return 32'(x * y);
  endfunction

  task automatic test_reset();
    rst = 1'b1; load8 = 1'b0; load16 = 1'b0;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (p8 !== 16'h0) begin n_fail++; $display("FAIL reset_p8 got=%h want=0", p8); end
    n_tests++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy8 got=%b want=0", busy8); end
    n_tests++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL reset_done8 got=%b want=0", done8); end
    n_tests++; if (p16 !== 32'h0 || busy16 !== 1'b0 || done16 !== 1'b0) begin
      n_fail++; $display("FAIL reset_16 got p=%h busy=%b done=%b want 0/0/0", p16, busy16, done16);
    end
    rst = 1'b0;
    last_p8 = '0; last_p16 = '0;
  endtask

  // Issue one operation on the 8-bit unit and follow it to its done cycle.
  // Returns with the DUT in its done cycle so the caller may load again.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit poke, input string nm);
    logic [15:0] exp;
    int cyc;
    exp = ref8(a, b);
    load8 = 1'b1; a8 = a; b8 = b;
    @(posedge clk); #1;
    load8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    n_tests++; if (busy8 !== 1'b1 || done8 !== 1'b0) begin
      n_fail++; $display("FAIL %s_accept got busy=%b done=%b want 1/0", nm, busy8, done8);
    end
    cyc = 0;
    while (done8 !== 1'b1 && cyc < 20) begin
      if (poke && cyc == 3) begin
        load8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
      end
      @(posedge clk); #1;
      load8 = 1'b0;
      cyc++;
      if (done8 !== 1'b1 && cyc < 8) begin
        n_tests++; if (p8 !== last_p8 || busy8 !== 1'b1) begin
          n_fail++; $display("FAIL %s_hold cyc=%0d got p=%h busy=%b want p=%h busy=1", nm, cyc, p8, busy8, last_p8);
        end
      end
    end
    n_tests++; if (cyc != 8 || done8 !== 1'b1) begin
      n_fail++; $display("FAIL %s_latency got=%0d cycles done=%b want 8 cycles done=1", nm, cyc, done8);
    end
    n_tests++; if (p8 !== exp || busy8 !== 1'b0) begin
      n_fail++; $display("FAIL %s_product got p=%h busy=%b want p=%h busy=0", nm, p8, busy8, exp);
    end
    last_p8 = exp;
  endtask

  task automatic idle8(input string nm);
    @(posedge clk); #1;
    n_tests++; if (done8 !== 1'b0 || busy8 !== 1'b0 || p8 !== last_p8) begin
      n_fail++; $display("FAIL %s_idle got done=%b busy=%b p=%h want 0/0/%h", nm, done8, busy8, p8, last_p8);
    end
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input int idx);
    logic [31:0] exp;
    int cyc;
    exp = ref16(a, b);
    load16 = 1'b1; a16 = a; b16 = b;
    @(posedge clk); #1;
    load16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    cyc = 0;
    while (done16 !== 1'b1 && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_tests++; if (cyc != 16 || p16 !== exp) begin
      n_fail++; $display("FAIL rand16_%0d a=%h b=%h got p=%h after %0d cycles want p=%h after 16", idx, a, b, p16, cyc, exp);
    end
    last_p16 = exp;
  endtask

  task automatic test_basic();
    run8(8'h08, 8'h08, 1'b0, "mul_8x8");
    idle8("mul_8x8");
    run8(8'hFF, 8'hFF, 1'b0, "mul_ffxff");
    idle8("mul_ffxff");
    run8(8'h00, 8'hA5, 1'b0, "mul_zero_a");
    idle8("mul_zero_a");
    run8(8'h5C, 8'h00, 1'b0, "mul_zero_b");
    idle8("mul_zero_b");
  endtask

  task automatic test_back_to_back();
    run8(8'hFF, 8'hFF, 1'b0, "b2b_first");
    run8(8'h03, 8'h07, 1'b0, "b2b_second");
    idle8("b2b_second");
  endtask

  task automatic test_ignored_load();
    run8(8'h5A, 8'h3C, 1'b1, "ignored_load");
    idle8("ignored_load");
  endtask

  task automatic test_abort();
    bit seen;
    load8 = 1'b1; a8 = 8'h10; b8 = 8'h10;
    @(posedge clk); #1;
    load8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_p8 = '0; last_p16 = '0;
    n_tests++; if (busy8 !== 1'b0 || p8 !== 16'h0 || done8 !== 1'b0) begin
      n_fail++; $display("FAIL abort_state got busy=%b p=%h done=%b want 0/0/0", busy8, p8, done8);
    end
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 === 1'b1 || busy8 === 1'b1) seen = 1'b1;
    end
    n_tests++; if (seen) begin n_fail++; $display("FAIL abort_no_done got activity=1 want 0"); end
    // Reset and load on the same edge: reset must win.
    rst = 1'b1; load8 = 1'b1; a8 = 8'h05; b8 = 8'h05;
    @(posedge clk); #1;
    rst = 1'b0; load8 = 1'b0;
    n_tests++; if (busy8 !== 1'b0 || p8 !== 16'h0) begin
      n_fail++; $display("FAIL rst_load_busy got busy=%b p=%h want 0/0", busy8, p8);
    end
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 === 1'b1 || busy8 === 1'b1) seen = 1'b1;
    end
    n_tests++; if (seen) begin n_fail++; $display("FAIL rst_load_idle got activity=1 want 0"); end
  endtask

  task automatic test_signed_vectors();
    run8(8'hFD, 8'h05, 1'b0, "vec_m3x5");
    run8(8'h80, 8'h80, 1'b0, "vec_m128xm128");
    run8(8'h7F, 8'hFF, 1'b0, "vec_127xm1");
    idle8("vec_127xm1");
  endtask

  task automatic test_random8();
    for (int i = 0; i < 20; i++) begin
      run8(8'($urandom), 8'($urandom), bit'($urandom_range(0, 1)), "rand8");
    end
    idle8("rand8");
  endtask

  task automatic test_random16();
    run16(16'hFFFF, 16'hFFFF, -1);
    run16(16'h8000, 16'h8000, -2);
    for (int i = 0; i < 200; i++) begin
      run16(16'($urandom), 16'($urandom), i);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignored_load();
    test_abort();
    test_signed_vectors();
    test_random8();
    test_random16();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
